// File: rtl/count_pkg.sv
// Shared types and widths for the counter sample path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// CNT_W    : width of the counter value being sampled
// EPOCH_W  : width of the wrap-epoch tag (wraps modulo 2^EPOCH_W)
// SAMPLE_W : total width of one stored sample
// sample_t : {epoch, count}; epoch in the upper bits so that a plain
//            unsigned compare of two samples orders them in time
package count_pkg;

    localparam int CNT_W    = 4;
    localparam int EPOCH_W  = 4;
    localparam int SAMPLE_W = CNT_W + EPOCH_W;

    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [CNT_W-1:0]   count;
    } sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO: register storage, wrap-extended pointers, occupancy.
// Latency: a push is visible at head_data/head_valid the cycle after it is accepted.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset (0 = reset)
//   push, push_data     write request and data
//   pop                 consume head entry (ignored when empty)
//   head_data           head entry, 0 when empty
//   head_valid          FIFO not empty
//   level               occupancy 0..DEPTH
//   full                level == DEPTH
module sample_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int LVL_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [LVL_W-1:0]  level,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    // One extra bit beyond the index distinguishes full from empty, so
    // the difference of the two counters is the occupancy directly.
    logic [LVL_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LVL_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign level      = wr_cnt_q - rd_cnt_q;
    assign empty      = (level == '0);
    assign full       = (level == LVL_W'(DEPTH));
    assign do_pop     = pop && !empty;
    // A slot freed by a same-cycle pop may be reused immediately.
    assign do_push    = push && (!full || do_pop);
    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem_q[rd_cnt_q[IDX_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (do_push) begin
            mem_d[wr_cnt_q[IDX_W-1:0]] = push_data;
            wr_cnt_d                   = wr_cnt_q + LVL_W'(1);
        end
        if (do_pop) begin
            rd_cnt_d = rd_cnt_q + LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

endmodule

// File: rtl/count_sample_queue.sv
// Snapshots the counter on capture, tags it with a wrap epoch, queues it for a host.
// Latency: capture -> out_valid one cycle when empty; one sample per cycle sustained.
// Backpressure: out_valid/out_ready; captures into a full, non-draining queue are dropped and flagged.
//
// Ports:
//   clk        rising-edge clock shared with the counter
//   rst        asynchronous active-low reset (0 = reset)
//   count_in   counter value, observed every cycle for wrap detection
//   capture    take a sample this cycle
//   out_data   {epoch, count} at queue head (0 when empty)
//   out_valid  head entry valid
//   out_ready  consumer accepts head this cycle
//   level      occupancy 0..DEPTH
//   overflow   sticky: a capture was dropped because the queue was full
//   clear_ovf  synchronous clear of overflow (loses to a same-cycle drop)
module count_sample_queue
    import count_pkg::*;
#(
    parameter int WIDTH   = count_pkg::CNT_W,
    parameter int EPOCH_W = count_pkg::EPOCH_W,
    parameter int DEPTH   = 4,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     capture,
    output logic [EPOCH_W+WIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LVL_W-1:0]         level,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    logic [WIDTH-1:0]   prev_count_q, prev_count_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               overflow_q, overflow_d;
    logic               wrap;
    logic [EPOCH_W-1:0] epoch_next;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               drop;

    // The counter only moves forward, so a decrease means it wrapped.
    assign wrap       = (count_in < prev_count_q);
    // The sample taken in the wrap cycle already belongs to the new epoch.
    assign epoch_next = epoch_q + EPOCH_W'(wrap);

    assign pop  = out_valid && out_ready;
    assign push = capture && (!fifo_full || pop);
    assign drop = capture && fifo_full && !pop;

    always_comb begin
        prev_count_d = count_in;
        epoch_d      = epoch_next;
        overflow_d   = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_count_q <= '0;
            epoch_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            prev_count_q <= prev_count_d;
            epoch_q      <= epoch_d;
            overflow_q   <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    sample_fifo #(
        .DATA_W (EPOCH_W + WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  ({epoch_next, count_in}),
        .pop        (pop),
        .head_data  (out_data),
        .head_valid (out_valid),
        .level      (level),
        .full       (fifo_full)
    );

endmodule

// File: tb/tb_count_sample_queue.sv
// Randomised and directed bench for count_sample_queue against a queue-based reference model.
module tb_count_sample_queue;
    import count_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count_in;
    logic       capture;
    logic       out_ready;
    logic       clear_ovf;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] level;
    logic       overflow;

    always #5 clk = ~clk;

    count_sample_queue #(
        .WIDTH   (4),
        .EPOCH_W (4),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .capture   (capture),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of samples plus epoch/previous-count bookkeeping.
    sample_t m_q[$];
    int      m_prev;
    int      m_epoch;
    bit      m_ovf;

    logic [3:0] cnt3 [3] = '{4'd15, 4'd0, 4'd3};
    logic [7:0] exp3 [3] = '{8'h0F, 8'h10, 8'h13};
    logic [7:0] exp5 [4] = '{8'h03, 8'h04, 8'h05, 8'h08};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev  = 0;
        m_epoch = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step();
        bit      pop;
        bit      full;
        bit      wrap;
        sample_t s;
        pop     = (m_q.size() != 0) && out_ready;
        full    = (m_q.size() == DEPTH);
        wrap    = (int'(count_in) < m_prev);
        m_epoch = (m_epoch + (wrap ? 1 : 0)) % 16;
        s.epoch = 4'(m_epoch);
        s.count = count_in;
        if (pop) void'(m_q.pop_front());
        if (capture && (!full || pop)) m_q.push_back(s);
        if (capture && full && !pop) m_ovf = 1'b1;
        else if (clear_ovf)          m_ovf = 1'b0;
        m_prev = int'(count_in);
    endtask

    task automatic compare_all();
        logic [7:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : 8'h00;
        check_eq("valid",    32'(out_valid), 32'(m_q.size() != 0));
        check_eq("level",    32'(level),     32'(m_q.size()));
        check_eq("overflow", 32'(overflow),  32'(m_ovf));
        check_eq("data",     32'(out_data),  32'(exp_data));
    endtask

    // One clock: the model consumes the inputs present at the edge, outputs are compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear with no clock edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_level",    32'(level),     32'd0);
        check_eq("arst_valid",    32'(out_valid), 32'd0);
        check_eq("arst_overflow", 32'(overflow),  32'd0);
        check_eq("arst_data",     32'(out_data),  32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset with random inputs
        rst       = 1'b0;
        count_in  = 4'($urandom);
        capture   = 1'($urandom);
        out_ready = 1'($urandom);
        clear_ovf = 1'($urandom);
        model_reset();
        repeat (2) cycle();
        count_in  = 4'd0;
        capture   = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle();
        check_eq("t1_hold_level", 32'(level), 32'd0);

        // Single capture at count 5
        count_in  = 4'd5;
        capture   = 1'b1;
        out_ready = 1'b1;
        cycle();
        check_eq("t2_valid", 32'(out_valid), 32'd1);
        check_eq("t2_data",  32'(out_data),  32'h05);
        capture = 1'b0;
        cycle();
        check_eq("t2_gone", 32'(out_valid), 32'd0);

        // Wrap across 15 -> 0
        for (int i = 0; i < 3; i++) begin
            count_in = cnt3[i];
            capture  = 1'b1;
            cycle();
            check_eq("t3_data", 32'(out_data), 32'(exp3[i]));
        end
        capture = 1'b0;
        cycle();

        // Fill past capacity from a fresh epoch
        pulse_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            count_in = 4'(2 + i);
            capture  = 1'b1;
            cycle();
        end
        check_eq("t4_level", 32'(level),    32'd4);
        check_eq("t4_ovf",   32'(overflow), 32'd1);
        check_eq("t4_head",  32'(out_data), 32'h02);

        // Full with a simultaneous pop: the new sample is accepted at the tail
        count_in  = 4'd8;
        capture   = 1'b1;
        out_ready = 1'b1;
        cycle();
        check_eq("t5_level", 32'(level),    32'd4);
        check_eq("t5_ovf",   32'(overflow), 32'd1);
        capture = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("t5_drain", 32'(out_data), 32'(exp5[i]));
            cycle();
        end
        check_eq("t5_empty", 32'(out_valid), 32'd0);

        // Overflow clear with and without a concurrent drop
        clear_ovf = 1'b1;
        cycle();
        check_eq("t6_clear", 32'(overflow), 32'd0);
        clear_ovf = 1'b0;
        out_ready = 1'b0;
        capture   = 1'b1;
        repeat (4) cycle();
        clear_ovf = 1'b1;
        cycle();
        check_eq("t6_drop_wins", 32'(overflow), 32'd1);
        clear_ovf = 1'b0;
        capture   = 1'b0;
        out_ready = 1'b1;
        repeat (2) cycle();
        check_eq("t6_midfill", 32'(level), 32'd2);
        pulse_reset();

        // Randomised traffic with changing drain pressure
        count_in = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) count_in = 4'($urandom);
            else if ($urandom_range(0, 3) != 0) count_in = count_in + 4'd1;
            capture   = ($urandom_range(0, 9) < 6);
            out_ready = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
            clear_ovf = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
